// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: two-requester round-robin access controller for a
// bank of four DW-bit registers (a, b, c, d shown on w, x, y, z).
//
// Handshake: a requester holds reqN (with weN/addrN/wdataN) until it sees
// doneN. The arbiter samples the request in IDLE, latches the operation
// at grant, owns the bank for one ACCESS cycle (gntN = 1), then pulses
// doneN for one DONE cycle with rdataN valid. Nothing the requester does
// after the grant edge affects the transaction in flight.
module shared_reg_arbiter #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          we0,
    input  logic [1:0]    addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          done0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [1:0]    addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          done1,
    output logic [DW-1:0] rdata1,
    output logic [DW-1:0] w,
    output logic [DW-1:0] x,
    output logic [DW-1:0] y,
    output logic [DW-1:0] z,
    output logic [1:0]    state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          win_q, win_d;      // id of the requester that owns the bank
    logic          we_q, we_d;
    logic [1:0]    addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          ptr_q, ptr_d;      // requester favoured on a tie
    logic [DW-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
    logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic          pick;
    logic [DW-1:0] rd_val;

    // State, latched transaction, bank and read-data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            win_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 2'd0;
            wdata_q  <= '0;
            ptr_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            d_q      <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            ptr_q    <= ptr_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            d_q      <= d_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Next-state logic: arbitration in IDLE, bank access in ACCESS,
    // pointer rotation in DONE.
    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        ptr_d    = ptr_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        d_d      = d_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        pick     = (req0 && req1) ? ptr_q : req1;

        case (addr_q)
            2'd0:    rd_val = a_q;
            2'd1:    rd_val = b_q;
            2'd2:    rd_val = c_q;
            default: rd_val = d_q;
        endcase

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    win_d   = pick;
                    we_d    = pick ? we1 : we0;
                    addr_d  = pick ? addr1 : addr0;
                    wdata_d = pick ? wdata1 : wdata0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (we_q) begin
                    case (addr_q)
                        2'd0:    a_d = wdata_q;
                        2'd1:    b_d = wdata_q;
                        2'd2:    c_d = wdata_q;
                        default: d_d = wdata_q;
                    endcase
                end else if (win_q) begin
                    rdata1_d = rd_val;
                end else begin
                    rdata0_d = rd_val;
                end
                state_d = DONE;
            end
            DONE: begin
                ptr_d   = ~win_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign gnt0    = (state_q == ACCESS) && !win_q;
    assign gnt1    = (state_q == ACCESS) &&  win_q;
    assign done0   = (state_q == DONE)   && !win_q;
    assign done1   = (state_q == DONE)   &&  win_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;
    assign w       = a_q;
    assign x       = b_q;
    assign y       = c_q;
    assign z       = d_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed testbench for shared_reg_arbiter.
module tb_shared_reg_arbiter;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [1:0]    addr0 = 2'd0, addr1 = 2'd0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          gnt0, done0, gnt1, done1;
    logic [DW-1:0] rdata0, rdata1, w, x, y, z;
    logic [1:0]    state_o;

    int tests = 0;
    int fails = 0;
    int done_cnt;
    logic [31:0] exp_q[$];
    logic [31:0] gnt_q[$];

    shared_reg_arbiter #(.DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .done0(done0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .done1(done1), .rdata1(rdata1),
        .w(w), .x(x), .y(y), .z(z), .state_o(state_o)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Advance one rising edge and settle on the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_bank(input string tag, input logic [DW-1:0] ea, input logic [DW-1:0] eb,
                              input logic [DW-1:0] ec, input logic [DW-1:0] ed);
        check({tag, "_w"}, 32'(w), 32'(ea));
        check({tag, "_x"}, 32'(x), 32'(eb));
        check({tag, "_y"}, 32'(y), 32'(ec));
        check({tag, "_z"}, 32'(z), 32'(ed));
    endtask

    task automatic check_hs(input string tag, input logic g0, input logic g1,
                            input logic d0, input logic d1);
        check(tag, 32'({gnt0, gnt1, done0, done1}), 32'({g0, g1, d0, d1}));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Directed stimulus sequence.
    initial begin
        // Reset and idle for five cycles.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check_bank("rst_bank", 8'h00, 8'h00, 8'h00, 8'h00);
        check_hs("rst_hs", 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_rdata", 32'({rdata0, rdata1}), 32'd0);

        // Single write c = 5A from requester 0.
        req0 = 1'b1; we0 = 1'b1; addr0 = 2'd2; wdata0 = 8'h5A;
        tick();
        check_hs("wr_access", 1'b1, 1'b0, 1'b0, 1'b0);
        check("wr_access_state", 32'(state_o), 32'd1);
        check("wr_y_before", 32'(y), 32'h00);
        tick();
        check_hs("wr_done", 1'b0, 1'b0, 1'b1, 1'b0);
        check("wr_y_after", 32'(y), 32'h5A);
        req0 = 1'b0;
        tick();
        check("wr_idle_state", 32'(state_o), 32'd0);
        check_bank("wr_bank", 8'h00, 8'h00, 8'h5A, 8'h00);

        // Race: both requesters fire together, grants go 0,1,0,1.
        do_reset();
        req0 = 1'b1; we0 = 1'b1; addr0 = 2'd0; wdata0 = 8'h00;
        req1 = 1'b1; we1 = 1'b1; addr1 = 2'd1; wdata1 = 8'h01;
        tick();
        check_hs("race_g1", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check_hs("race_d1", 1'b0, 1'b0, 1'b1, 1'b0);
        we0 = 1'b0; addr0 = 2'd1;
        tick();
        check_hs("race_idle1", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_hs("race_g2", 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        check_hs("race_d2", 1'b0, 1'b0, 1'b0, 1'b1);
        check("race_b_written", 32'(x), 32'h01);
        we1 = 1'b0; addr1 = 2'd0;
        tick();
        tick();
        check_hs("race_g3", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check_hs("race_d3", 1'b0, 1'b0, 1'b1, 1'b0);
        check("race_rdata0_b", 32'(rdata0), 32'h01);
        req0 = 1'b0;
        tick();
        tick();
        check_hs("race_g4", 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        check_hs("race_d4", 1'b0, 1'b0, 1'b0, 1'b1);
        check("race_rdata1_a", 32'(rdata1), 32'h00);
        check("race_rdata0_hold", 32'(rdata0), 32'h01);
        req1 = 1'b0;
        tick();
        check_bank("race_bank", 8'h00, 8'h01, 8'h00, 8'h00);

        // Continuous requests from both sides for 12 cycles after reset.
        @(negedge clk);
        rst_n = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 2'd1;
        req1 = 1'b1; we1 = 1'b0; addr1 = 2'd0;
        tick();
        rst_n = 1'b1;
        exp_q = '{32'd0, 32'd1, 32'd0, 32'd1};
        gnt_q = {};
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (gnt0) gnt_q.push_back(32'd0);
            if (gnt1) gnt_q.push_back(32'd1);
            if (done0 || done1) done_cnt++;
            check("cont_excl", 32'(32'(gnt0) + 32'(gnt1) + 32'(done0) + 32'(done1) <= 1), 32'd1);
        end
        check("cont_done_cnt", 32'(done_cnt), 32'd4);
        check("cont_gnt_cnt", 32'(gnt_q.size()), 32'd4);
        while (exp_q.size() > 0 && gnt_q.size() > 0) begin
            check("cont_gnt_order", gnt_q.pop_front(), exp_q.pop_front());
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();

        // Requester 1 writes b = FF, then drops req and changes data.
        req1 = 1'b1; we1 = 1'b1; addr1 = 2'd1; wdata1 = 8'hFF;
        tick();
        check_hs("drop_access", 1'b0, 1'b1, 1'b0, 1'b0);
        req1 = 1'b0; wdata1 = 8'h11;
        tick();
        check_hs("drop_done", 1'b0, 1'b0, 1'b0, 1'b1);
        check("drop_x", 32'(x), 32'hFF);
        tick();
        check("drop_x_hold", 32'(x), 32'hFF);
        check("drop_idle", 32'(state_o), 32'd0);

        // Reset during ACCESS of a write d = 33.
        req0 = 1'b1; we0 = 1'b1; addr0 = 2'd3; wdata0 = 8'h33;
        tick();
        check_hs("abort_access", 1'b1, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_hs("abort_hs", 1'b0, 1'b0, 1'b0, 1'b0);
        check_bank("abort_bank", 8'h00, 8'h00, 8'h00, 8'h00);
        check("abort_state", 32'(state_o), 32'd0);
        req0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        check_bank("abort_post", 8'h00, 8'h00, 8'h00, 8'h00);
        check_hs("abort_post_hs", 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/shared_reg_arbiter.md
Name: shared_reg_arbiter

Overview:
Deterministic two-requester access controller for a shared bank of four registers (a, b, c, d), exposed as outputs w, x, y, z. It replaces unordered concurrent writes and reads with round-robin granted, single-owner transactions. Every read or write therefore has one defined ordering and one defined final value. It sits between two independent requester processes and the shared register bank.

Parameters:
DW, 8, data width of each shared register and of the read/write data ports.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
req0  input  1  requester 0 access request; held until done0.
we0  input  1  requester 0 op: 1 = write, 0 = read.
addr0  input  2  requester 0 register select: 0=a, 1=b, 2=c, 3=d.
wdata0  input  DW  requester 0 write data.
gnt0  output  1  requester 0 owns the bank (ACCESS cycle).
done0  output  1  one-cycle completion pulse for requester 0.
rdata0  output  DW  requester 0 read data; valid while done0 = 1.
req1, we1, addr1, wdata1, gnt1, done1, rdata1: same as above, for requester 1.
w, x, y, z  output  DW each  current contents of registers a, b, c, d.

Behaviour:
- Reset (rst_n low, asynchronous): a, b, c, d = 0; gnt0/1 = 0; done0/1 = 0; rdata0/1 = 0; state = IDLE; priority pointer = 0 (requester 0 favoured).
- FSM states: IDLE, ACCESS, DONE.
- IDLE: if no req, stay. If exactly one req, grant it. If both, grant the requester named by the pointer. On grant, latch winner id, we, addr and wdata, then go to ACCESS.
- ACCESS (1 cycle): gnt of the winner = 1.
  - Write: the selected register takes the latched wdata at the end of this cycle.
  - Read: the selected register value is captured into rdata of the winner.
  - Go to DONE.
- DONE (1 cycle): done of the winner = 1 and rdata valid. Pointer moves to the other requester. Go to IDLE.
- Latency: req first sampled high at edge T → gnt high during cycle T+1 → done high during cycle T+2. A write is visible on w/x/y/z from cycle T+2. Each transaction takes 3 cycles including IDLE arbitration.
- Fairness: continuous requests from both sides alternate strictly, 0,1,0,1... (pointer reset value 0). A single requester can issue back-to-back transactions every 3 cycles.
- Inputs are latched at grant. Deasserting req or changing we/addr/wdata during ACCESS or DONE does not affect the transaction in flight.
- gnt and done are never high for both requesters in the same cycle, and gnt and done are never high together.
- rdata of each requester holds its last read value until that requester's next read. Write transactions do not change rdata.
- A reset mid-transaction aborts it: no register update, all outputs return to reset values.
- The shared registers change only in ACCESS and only for a write. Reads never modify the bank.

Test Plan:
- After reset, no requests for 5 cycles → w=x=y=z=0, all gnt/done=0, state IDLE.
- req0 write addr0=2, wdata0=8'h5A at edge T → gnt0 in T+1, done0 in T+2, y=8'h5A from T+2; gnt1/done1 stay 0.
- Race ordering: both requests fire in the same cycle; req0 = write a=8'h00 then read b, req1 = write b=8'h01 then read a (each reasserted after done) → grant order 0,1,0,1. Required results: req0 reads b=8'h01, req1 reads a=8'h00; final a=00, b=01.
- Both requesters continuously requesting for 12 cycles from reset → grants alternate 0,1,0,1, with exactly 4 done pulses.
- Grant req1 write x=8'hFF, then drop req1 and change wdata1 to 8'h11 during ACCESS → x=8'hFF, done1 still pulses.
- Assert rst_n low during ACCESS of a write z=8'h33 → z=0, gnt/done=0 immediately; after release, the bank stays all-zero until a new request arrives.
